conv_scheduler: RTL and testbench

CONV_SCHEDULER -- requirements
Module: conv_scheduler

---
 rtl/conv_scheduler_pkg.sv | 42 ++++
 rtl/sched_pkt_out.sv | 31 +++
 rtl/conv_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_conv_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_scheduler_pkg.sv
// Purpose: shared packet field layout, type codes, node IDs and FSM state codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package conv_scheduler_pkg;

    // Mesh packet field layout: {dest, src, type, timestep, payload}
    localparam int DEST_HI    = 52;
    localparam int DEST_LO    = 49;
    localparam int SRC_HI     = 48;
    localparam int SRC_LO     = 45;
    localparam int TYPE_HI    = 44;
    localparam int TYPE_LO    = 43;
    localparam int TS_HI      = 42;
    localparam int TS_LO      = 40;
    localparam int PAYLOAD_W  = 40;

    localparam logic [1:0] TYPE_FILT  = 2'b00;
    localparam logic [1:0] TYPE_IFMAP = 2'b01;
    localparam logic [1:0] TYPE_ACK   = 2'b10;

    localparam logic [3:0] NODE_CU  = 4'd12;   // this block
    localparam logic [3:0] NODE_OUT = 4'd3;    // output port, never a PE

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FILT     = 3'd1;
    localparam logic [2:0] ST_IFMAP    = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Lowest PE node index >= from; returns {1'b1, 4'h0} when there is none.
    function automatic logic [4:0] next_pe(input logic [15:0] mask, input logic [4:0] from);
        logic [4:0] r;
        r = 5'h10;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= from)) begin
                r = {1'b0, 4'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sched_pkt_out.sv
// Purpose: single-entry packet output register toward the router PE port.
// Latency: 1 cycle from load to pkt_valid.
// Backpressure: pkt_valid/pkt_data held stable until pkt_ready; no ready->valid comb path.
// Ports: clk, rst (async, active-high), load/load_data (capture), pkt_ready in,
//        pkt_valid/pkt_data out.
module sched_pkt_out #(
    parameter int W = 53
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         pkt_ready,
    output logic         pkt_valid,
    output logic [W-1:0] pkt_data
);

    // load is only raised by the scheduler when the slot is empty or draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
        end else if (load) begin
            pkt_valid <= 1'b1;
            pkt_data  <= load_data;
        end else if (pkt_valid && pkt_ready) begin
            pkt_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Purpose: streams filter then per-timestep ifmap packets to every PE and collects acks.
// Latency: read at cycle t, packet valid at t+2; at best one packet every 2 cycles.
// Backpressure: next memory read waits for the held packet to be accepted.
// Ports: clk, rst (async, active-high), start; mem_rd_en/mem_sel/mem_addr, mem_rd_data;
//        pkt_valid/pkt_ready/pkt_data; ack_valid/ack_data; busy/done/err status.
module conv_scheduler
    import conv_scheduler_pkg::*;
#(
    parameter int          PKT_WIDTH  = 53,
    parameter logic [15:0] PE_MASK    = 16'hEFF7,
    parameter int          FILT_PKTS  = 5,
    parameter int          IFMAP_PKTS = 5,
    parameter int          NUM_TS     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 mem_rd_en,
    output logic                 mem_sel,
    output logic [7:0]           mem_addr,
    input  logic [39:0]          mem_rd_data,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic [PKT_WIDTH-1:0] pkt_data,
    input  logic                 ack_valid,
    input  logic [PKT_WIDTH-1:0] ack_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [3:0] FIRST_NODE = 4'(next_pe(PE_MASK, 5'd0));

    logic [2:0]  state;
    logic [2:0]  ts;
    logic [3:0]  node;
    logic [7:0]  k;
    logic        all_issued;   // every packet of the current phase has been read
    logic        rd_pend;      // read data is on mem_rd_data this cycle
    logic [3:0]  rd_node;
    logic [15:0] ack_mask;

    logic        sending;
    logic        slot_free;
    logic        issue;
    logic        phase_end;
    logic        last_k;
    logic [7:0]  last_idx;
    logic [4:0]  nxt_pe;
    logic [PKT_WIDTH-1:0] load_pkt;

    logic [3:0]  ack_src;
    logic [1:0]  ack_type;
    logic [2:0]  ack_ts;
    logic        ack_in_run;
    logic        ack_ok;
    logic        ack_unused;

    assign sending   = (state == ST_FILT) || (state == ST_IFMAP);
    // Slot is free once no read is in flight and the held packet is gone or leaving now.
    assign slot_free = !rd_pend && (!pkt_valid || pkt_ready);
    assign issue     = sending && !all_issued && slot_free;
    assign phase_end = sending && all_issued && slot_free;

    assign last_idx = (state == ST_IFMAP) ? 8'(IFMAP_PKTS - 1) : 8'(FILT_PKTS - 1);
    assign last_k   = (k == last_idx);
    assign nxt_pe   = next_pe(PE_MASK, {1'b0, node} + 5'd1);

    assign mem_rd_en = issue;
    assign mem_sel   = (state == ST_IFMAP);
    // Both address forms are taken mod 256, so 8-bit arithmetic is exact.
    assign mem_addr  = mem_sel ? ({1'b0, ts, node} * 8'(IFMAP_PKTS) + k)
                               : ({4'd0, node} * 8'(FILT_PKTS) + k);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // State cannot change while a read is pending, so type/ts come from live state.
    always_comb begin
        load_pkt = '0;
        load_pkt[DEST_HI:DEST_LO] = rd_node;
        load_pkt[SRC_HI:SRC_LO]   = NODE_CU;
        load_pkt[TYPE_HI:TYPE_LO] = (state == ST_IFMAP) ? TYPE_IFMAP : TYPE_FILT;
        load_pkt[TS_HI:TS_LO]     = ts;
        load_pkt[PAYLOAD_W-1:0]   = mem_rd_data;
    end

    assign ack_src    = ack_data[SRC_HI:SRC_LO];
    assign ack_type   = ack_data[TYPE_HI:TYPE_LO];
    assign ack_ts     = ack_data[TS_HI:TS_LO];
    assign ack_unused = ^{ack_data[DEST_HI:DEST_LO], ack_data[PAYLOAD_W-1:0]};
    assign ack_in_run = (state == ST_FILT) || (state == ST_IFMAP) || (state == ST_WAIT_ACK);
    assign ack_ok     = ack_in_run && (ack_type == TYPE_ACK) && (ack_ts == ts)
                        && PE_MASK[ack_src] && !ack_mask[ack_src];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ts         <= '0;
            node       <= '0;
            k          <= '0;
            all_issued <= 1'b0;
            rd_pend    <= 1'b0;
            rd_node    <= '0;
            ack_mask   <= '0;
            err        <= 1'b0;
        end else begin
            rd_pend <= issue;

            if (issue) begin
                rd_node <= node;
                if (last_k) begin
                    k <= '0;
                    if (nxt_pe[4]) begin
                        all_issued <= 1'b1;
                    end else begin
                        node <= nxt_pe[3:0];
                    end
                end else begin
                    k <= k + 8'd1;
                end
            end

            if (ack_valid) begin
                if (ack_ok) begin
                    ack_mask[ack_src] <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_FILT;
                        ts         <= '0;
                        ack_mask   <= '0;
                        node       <= FIRST_NODE;
                        k          <= '0;
                        all_issued <= 1'b0;
                    end
                end
                ST_FILT: begin
                    if (phase_end) begin
                        state      <= ST_IFMAP;
                        node       <= FIRST_NODE;
                        k          <= '0;
                        all_issued <= 1'b0;
                    end
                end
                ST_IFMAP: begin
                    if (phase_end) begin
                        state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_mask == PE_MASK) begin
                        ack_mask <= '0;
                        ts       <= ts + 3'd1;
                        if (ts == 3'(NUM_TS - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            state      <= ST_IFMAP;
                            node       <= FIRST_NODE;
                            k          <= '0;
                            all_issued <= 1'b0;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    sched_pkt_out #(.W(PKT_WIDTH)) u_pkt_out (
        .clk       (clk),
        .rst       (rst),
        .load      (rd_pend),
        .load_data (load_pkt),
        .pkt_ready (pkt_ready),
        .pkt_valid (pkt_valid),
        .pkt_data  (pkt_data)
    );

endmodule

// File: tb/tb_conv_scheduler.sv
// Purpose: scoreboard bench for conv_scheduler with a queue-based reference model.
// Latency: n/a.
// Backpressure: random pkt_ready in selected runs.
module tb_conv_scheduler;

    localparam logic [15:0] MASK = 16'hEFF7;
    localparam int FP = 5;
    localparam int IP = 5;
    localparam int NT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mem_rd_en, mem_sel;
    logic [7:0]  mem_addr;
    logic [39:0] mem_rd_data;
    logic        pkt_valid, pkt_ready;
    logic [52:0] pkt_data;
    logic        ack_valid;
    logic [52:0] ack_data;
    logic        busy, done, err;

    logic        s_rst, s_start, s_mem_rd_en, s_mem_sel;
    logic [7:0]  s_mem_addr;
    logic [39:0] s_mem_rd_data;
    logic        s_pkt_valid, s_pkt_ready;
    logic [52:0] s_pkt_data;
    logic        s_ack_valid;
    logic [52:0] s_ack_data;
    logic        s_busy, s_done, s_err;

    conv_scheduler u_dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .ack_valid(ack_valid), .ack_data(ack_data),
        .busy(busy), .done(done), .err(err)
    );

    conv_scheduler #(.PE_MASK(16'h0001), .FILT_PKTS(1), .IFMAP_PKTS(1), .NUM_TS(1)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start),
        .mem_rd_en(s_mem_rd_en), .mem_sel(s_mem_sel), .mem_addr(s_mem_addr), .mem_rd_data(s_mem_rd_data),
        .pkt_valid(s_pkt_valid), .pkt_ready(s_pkt_ready), .pkt_data(s_pkt_data),
        .ack_valid(s_ack_valid), .ack_data(s_ack_data),
        .busy(s_busy), .done(s_done), .err(s_err)
    );

    typedef struct { logic [52:0] pkt; bit last; int ts; bit ifm; } exp_t;
    typedef struct { logic [3:0] src; logic [2:0] ts; } ack_t;

    exp_t        exp_q[$];
    ack_t        ack_q[$];
    logic [15:0] acked [8];
    bit          seen_ts [8];
    int          n_ts [8];
    int          n_filt, n_ifm;
    int          checks = 0;
    int          failures = 0;
    bit          rnd_rdy = 1'b0;
    bit          small_fin = 1'b0;
    bit          held = 1'b0;
    logic [52:0] held_dat;

    function automatic logic [39:0] mem_val(input logic sel, input logic [7:0] a);
        logic [7:0] t;
        t = sel ? 8'hA5 : 8'h5A;
        return {t, a, a ^ 8'h3C, ~a, a + 8'h11};
    endfunction

    function automatic logic [52:0] mk_pkt(input int n, input logic [1:0] ty, input int t,
                                           input logic [39:0] pl);
        logic [3:0] nn;
        logic [2:0] tt;
        nn = 4'(n);
        tt = 3'(t);
        return {nn, 4'd12, ty, tt, pl};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic clear_trackers();
        n_filt = 0;
        n_ifm  = 0;
        held   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            acked[i]   = '0;
            seen_ts[i] = 1'b0;
            n_ts[i]    = 0;
        end
    endtask

    // Expected order: all filter packets, then per timestep all ifmap packets.
    task automatic build_expect();
        exp_t e;
        logic [15:0] m;
        m = MASK;
        exp_q.delete();
        for (int n = 0; n < 16; n++)
            if (m[n])
                for (int k = 0; k < FP; k++) begin
                    e.pkt = mk_pkt(n, 2'b00, 0, mem_val(1'b0, 8'((n * FP + k) % 256)));
                    e.last = 1'b0; e.ts = 0; e.ifm = 1'b0;
                    exp_q.push_back(e);
                end
        for (int t = 0; t < NT; t++)
            for (int n = 0; n < 16; n++)
                if (m[n])
                    for (int k = 0; k < IP; k++) begin
                        e.pkt = mk_pkt(n, 2'b01, t, mem_val(1'b1, 8'(((t * 16 + n) * IP + k) % 256)));
                        e.last = (k == IP - 1); e.ts = t; e.ifm = 1'b1;
                        exp_q.push_back(e);
                    end
    endtask

    // Memory models: data presented during the cycle after the read request.
    initial begin
        logic sel;
        logic [7:0] a;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_en && !rst) begin
                sel = mem_sel; a = mem_addr;
                @(posedge clk); #1;
                mem_rd_data = mem_val(sel, a);
            end
        end
    end

    initial begin
        logic sel;
        logic [7:0] a;
        s_mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (s_mem_rd_en) begin
                sel = s_mem_sel; a = s_mem_addr;
                @(posedge clk); #1;
                s_mem_rd_data = mem_val(sel, a);
            end
        end
    end

    initial begin
        pkt_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            pkt_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Ack driver: one ack per cycle from the queue.
    initial begin
        ack_t a;
        ack_valid = 1'b0;
        ack_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (ack_q.size() > 0 && !rst) begin
                a = ack_q.pop_front();
                ack_valid = 1'b1;
                ack_data  = {4'd12, a.src, 2'b10, a.ts, 40'd0};
                acked[a.ts] = acked[a.ts] | (16'd1 << a.src);
            end else begin
                ack_valid = 1'b0;
            end
        end
    end

    // Monitor: compares each accepted packet with the scoreboard head.
    initial begin
        exp_t e;
        ack_t a;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", 64'(pkt_valid), 64'(1));
                    chk("hold_data", 64'(pkt_data), 64'(held_dat));
                end
                if (pkt_valid && pkt_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_pkt actual=0x%0h required=none", pkt_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pkt_data", 64'(pkt_data), 64'(e.pkt));
                        if (e.ifm) begin
                            n_ifm++;
                            n_ts[e.ts]++;
                            if (e.ts > 0 && !seen_ts[e.ts])
                                chk("ts_advance", 64'(acked[e.ts-1] & MASK), 64'(MASK));
                            seen_ts[e.ts] = 1'b1;
                        end else begin
                            n_filt++;
                        end
                        if (e.last) begin
                            a.src = e.pkt[52:49];
                            a.ts  = 3'(e.ts);
                            ack_q.push_back(a);
                        end
                    end
                end
                held     = pkt_valid && !pkt_ready;
                held_dat = pkt_data;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        ack_q.delete();
        clear_trackers();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_err_clear", 64'(err), 64'(0));
    endtask

    task automatic start_run(input int extra_src);
        ack_t a;
        clear_trackers();
        build_expect();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (extra_src >= 0) begin
            a.src = 4'(extra_src);
            a.ts  = 3'd0;
            ack_q.push_back(a);
        end
    endtask

    task automatic finish_run(input string tag, input logic exp_err);
        int cyc;
        cyc = 0;
        while (!done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_timeout done not seen after %0d cycles", tag, cyc);
        end else begin
            chk({tag, "_busy_at_done"}, 64'(busy), 64'(1));
            chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'(0));
            chk({tag, "_filt_cnt"}, 64'(n_filt), 64'(70));
            chk({tag, "_ifmap_cnt"}, 64'(n_ifm), 64'(140));
            chk({tag, "_err"}, 64'(err), 64'(exp_err));
            @(negedge clk);
            chk({tag, "_done_pulse"}, 64'(done), 64'(0));
            chk({tag, "_idle"}, 64'(busy), 64'(0));
        end
    endtask

    // Reduced configuration: one PE, one packet of each kind, one timestep.
    initial begin
        int got, cyc;
        s_rst = 1'b1; s_start = 1'b0; s_ack_valid = 1'b0; s_ack_data = '0; s_pkt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 s_rst = 1'b0;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        got = 0; cyc = 0;
        while (got < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (s_pkt_valid) begin
                if (got == 0)
                    chk("small_filt", 64'(s_pkt_data), 64'({4'd0, 4'd12, 2'b00, 3'd0, mem_val(1'b0, 8'd0)}));
                else
                    chk("small_ifmap", 64'(s_pkt_data), 64'({4'd0, 4'd12, 2'b01, 3'd0, mem_val(1'b1, 8'd0)}));
                got++;
            end
        end
        chk("small_pkt_count", 64'(got), 64'(2));
        @(posedge clk); #1;
        s_ack_valid = 1'b1;
        s_ack_data  = {4'd12, 4'd0, 2'b10, 3'd0, 40'd0};
        @(posedge clk); #1 s_ack_valid = 1'b0;
        cyc = 0;
        while (!s_done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("small_done", 64'(s_done), 64'(1));
        chk("small_err", 64'(s_err), 64'(0));
        @(negedge clk);
        chk("small_idle", 64'(s_busy), 64'(0));
        small_fin = 1'b1;
    end

    initial begin
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        clear_trackers();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_pkt_valid", 64'(pkt_valid), 64'(0));
        chk("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
        chk("rst_pkt_data", 64'(pkt_data), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Full-rate run.
        rnd_rdy = 1'b0;
        start_run(-1);
        finish_run("runA", 1'b0);

        // Random backpressure plus a start pulse while busy (must be ignored).
        rnd_rdy = 1'b1;
        start_run(-1);
        repeat (40) @(negedge clk);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_run("runB", 1'b0);

        // Ack from the scheduler's own node is illegal.
        rnd_rdy = 1'b0;
        start_run(12);
        finish_run("runC", 1'b1);
        do_reset();

        // Early ack from node 5 makes its later ack a duplicate.
        rnd_rdy = 1'b1;
        start_run(5);
        finish_run("runD", 1'b0 | 1'b1);
        do_reset();

        // Reset in the middle of timestep-1 ifmap traffic, then replay.
        start_run(-1);
        cyc = 0;
        while (n_ts[1] < 3 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        while (!pkt_valid && cyc < 4100) begin
            @(negedge clk);
            cyc++;
        end
        chk("runE_reached_ts1_valid", 64'(pkt_valid && n_ts[1] >= 3), 64'(1));
        #2 rst = 1'b1;
        exp_q.delete();
        ack_q.delete();
        #1;
        chk("runE_rst_pkt_valid", 64'(pkt_valid), 64'(0));
        chk("runE_rst_idle", 64'(busy), 64'(0));
        chk("runE_rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
        chk("runE_rst_pkt_data", 64'(pkt_data), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        clear_trackers();
        repeat (3) @(negedge clk);
        chk("runE_no_resume", 64'(pkt_valid), 64'(0));
        start_run(-1);
        finish_run("runE", 1'b0);

        cyc = 0;
        while (!small_fin && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (!small_fin) begin
            checks++; failures++;
            $display("FAIL small_timeout reduced-config run not finished after %0d cycles", cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
